tone_divider_bank: RTL and testbench

Bank of CHANNELS independent programmable dividers that turn the system clock into square/pulse waves with per-channel period and duty, plus a one-cycle wrap pulse per channel. It is the multi-voice successor to the single fixed-50%-duty divider: full-period (not half-period) programming, programmable high time, glitch-free reconfiguration at period boundaries, and a global phase-sync strobe. Sits between the register/control front end and the voice mixer.

---
 rtl/tone_divider_pkg.sv | 15 +
 rtl/tone_divider_channel.sv | 69 ++++++
 rtl/tone_divider_bank.sv | 44 ++++
 tb/tb_tone_divider_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tone_divider_pkg.sv
// Shared definitions for the tone divider bank: default sizes and select-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tone_divider_pkg;

    localparam int CHANNELS_DEFAULT = 4;
    localparam int N_DEFAULT        = 16;

    // Width of a channel-select field; never narrower than one bit so a
    // single-channel bank still has a usable (and range-checkable) select.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tone_divider_channel.sv
// One divider voice: period/high counter with active and pending config, wave and tick flops.
// Latency: wave/tick registered, reflect the counter state loaded on the same edge.
// Backpressure: none; config writes are always accepted into the pending slot.
module tone_divider_channel
    import tone_divider_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         wr,
    input  logic [N-1:0] wr_period,
    input  logic [N-1:0] wr_high,
    input  logic         sync,
    output logic         wave,
    output logic         tick
);

    typedef struct packed {
        logic [N-1:0] period;
        logic [N-1:0] high;
    } cfg_t;

    cfg_t         active_q;
    cfg_t         pending_q;
    cfg_t         active_d;
    cfg_t         pending_d;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         wrap;

    // Next-state: a write lands in pending and, on any load boundary
    // (wrap, disable, sync), bypasses straight into active. Using >= keeps
    // the counter bounded even if active.period ever sits below cnt_q.
    always_comb begin
        pending_d = pending_q;
        if (wr) begin
            pending_d.period = wr_period;
            pending_d.high   = wr_high;
        end
        wrap     = en && !sync && (cnt_q >= active_q.period);
        active_d = active_q;
        cnt_d    = cnt_q + N'(1);
        if (sync || !en || wrap) begin
            cnt_d    = '0;
            active_d = pending_d;
        end
    end

    // State and output flops; wave compares the values being loaded so it
    // changes cleanly together with the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            wave      <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            wave      <= en && (cnt_d < active_d.high);
            tick      <= wrap;
        end
    end

endmodule

// File: rtl/tone_divider_bank.sv
// Bank of independent programmable period/duty dividers with wrap ticks and global phase sync.
// Latency: wave/tick registered; config applies at next wrap (enabled) or next cycle (disabled).
// Backpressure: none; out-of-range cfg_sel writes are silently dropped.
module tone_divider_bank
    import tone_divider_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEFAULT,
    parameter  int N        = N_DEFAULT,
    localparam int SW       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_wr,
    input  logic [SW-1:0]       cfg_sel,
    input  logic [N-1:0]        cfg_period,
    input  logic [N-1:0]        cfg_high,
    input  logic                sync,
    output logic [CHANNELS-1:0] wave,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] wr_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Select decode; indices >= CHANNELS never match any channel.
        assign wr_vec[i] = cfg_wr && (cfg_sel == SW'(i));

        tone_divider_channel #(
            .N (N)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .en        (en[i]),
            .wr        (wr_vec[i]),
            .wr_period (cfg_period),
            .wr_high   (cfg_high),
            .sync      (sync),
            .wave      (wave[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_tone_divider_bank.sv
module tb_tone_divider_bank;

    localparam int CH = 3;
    localparam int N  = 16;
    localparam int SW = 2;

    logic          clk;
    logic          rst;
    logic [CH-1:0] en;
    logic          cfg_wr;
    logic [SW-1:0] cfg_sel;
    logic [N-1:0]  cfg_period;
    logic [N-1:0]  cfg_high;
    logic          sync;
    logic [CH-1:0] wave;
    logic [CH-1:0] tick;

    tone_divider_bank #(
        .CHANNELS (CH),
        .N        (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_wr     (cfg_wr),
        .cfg_sel    (cfg_sel),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .sync       (sync),
        .wave       (wave),
        .tick       (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase position within the current period plus the
    // period/high in force and the values waiting for the next boundary.
    int phase [CH];
    int cur_p [CH];
    int cur_h [CH];
    int nxt_p [CH];
    int nxt_h [CH];

    typedef struct packed {
        logic [CH-1:0] wave;
        logic [CH-1:0] tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Predict the outputs that the coming clock edge will produce.
    task automatic model(input logic r, input logic [CH-1:0] e, input logic w,
                         input int s, input int p, input int h, input logic sy);
        exp_t x;
        x = '0;
        for (int i = 0; i < CH; i++) begin
            if (r) begin
                phase[i] = 0; cur_p[i] = 0; cur_h[i] = 0; nxt_p[i] = 0; nxt_h[i] = 0;
            end else begin
                bit end_of_period;
                if (w && s == i) begin
                    nxt_p[i] = p;
                    nxt_h[i] = h;
                end
                end_of_period = (phase[i] >= cur_p[i]);
                if (sy || !e[i] || end_of_period) begin
                    phase[i] = 0;
                    cur_p[i] = nxt_p[i];
                    cur_h[i] = nxt_h[i];
                end else begin
                    phase[i] = phase[i] + 1;
                end
                x.tick[i] = e[i] && !sy && end_of_period;
                x.wave[i] = e[i] && (phase[i] < cur_h[i]);
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic [CH-1:0] e, input logic w,
                        input int s, input int p, input int h, input logic sy);
        @(negedge clk);
        rst        = r;
        en         = e;
        cfg_wr     = w;
        cfg_sel    = SW'(s);
        cfg_period = N'(p);
        cfg_high   = N'(h);
        sync       = sy;
        model(r, e, w, s, p, h, sy);
    endtask

    task automatic idle(input logic [CH-1:0] e, input int n);
        for (int k = 0; k < n; k++) step(1'b0, e, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents wave/tick; compare against the
    // oldest prediction.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                cyc++;
                checks++;
                if (wave !== x.wave) begin
                    failures++;
                    $display("FAIL wave cyc=%0d got=%b exp=%b", cyc, wave, x.wave);
                end
                checks++;
                if (tick !== x.tick) begin
                    failures++;
                    $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, x.tick);
                end
            end
        end
    end

    initial begin
        logic [CH-1:0] en_r;
        rst = 1'b1; en = '0; cfg_wr = 1'b0; cfg_sel = '0;
        cfg_period = '0; cfg_high = '0; sync = 1'b0;

        // Reset, then all enabled with default P=0,H=0.
        step(1'b1, '0, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, '0, 1'b0, 0, 0, 0, 1'b0);
        idle(3'b111, 6);

        // ch0 P=3,H=2 written while disabled, then run.
        step(1'b0, 3'b110, 1'b1, 0, 3, 2, 1'b0);
        idle(3'b111, 16);

        // ch1 P=9,H=5 then mid-period reprogram to P=3,H=1.
        step(1'b0, 3'b111, 1'b1, 1, 9, 5, 1'b0);
        idle(3'b111, 15);
        step(1'b0, 3'b111, 1'b1, 1, 3, 1, 1'b0);
        idle(3'b111, 20);

        // ch0 P=4, ch1 P=6 drifting, then sync.
        step(1'b0, 3'b111, 1'b1, 0, 4, 2, 1'b0);
        step(1'b0, 3'b111, 1'b1, 1, 6, 3, 1'b0);
        idle(3'b111, 23);
        step(1'b0, 3'b111, 1'b0, 0, 0, 0, 1'b1);
        idle(3'b111, 40);

        // H=0 and H=20 with P=7 on ch2; out-of-range select.
        step(1'b0, 3'b111, 1'b1, 2, 7, 0, 1'b0);
        idle(3'b111, 16);
        step(1'b0, 3'b111, 1'b1, 2, 7, 20, 1'b0);
        idle(3'b111, 16);
        step(1'b0, 3'b111, 1'b1, 3, 5, 5, 1'b0);
        idle(3'b111, 10);

        // Sync coincident with a write on a wrapping/running channel.
        step(1'b0, 3'b111, 1'b1, 0, 2, 1, 1'b1);
        idle(3'b111, 8);

        // Pending write, then reset with sync and write in the same cycle.
        step(1'b0, 3'b111, 1'b1, 1, 9, 4, 1'b0);
        idle(3'b111, 3);
        step(1'b1, 3'b111, 1'b1, 2, 6, 3, 1'b1);
        idle(3'b111, 6);

        // Randomized traffic.
        en_r = 3'b111;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) en_r = CH'($urandom);
            step($urandom_range(0, 199) == 0, en_r, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                 int'($urandom_range(0, 12)), $urandom_range(0, 40) == 0);
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
